// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
// Opcodes, status flag bundle and control FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier.
// One partial product per cycle; WIDTH cycles from start to done.
module alu_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               run;
  logic [WIDTH:0]     upper;

  // Low half holds the unconsumed multiplier bits, high half the sum.
  always_comb begin
    upper = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      upper = upper + {1'b0, mcand};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (start) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= CW'(WIDTH);
      run   <= 1'b1;
    end else if (run) begin
      acc <= {upper, acc[WIDTH-1:1]};
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        run <= 1'b0;
      end
    end
  end

  assign product = acc;
  assign done    = run && (cnt == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit ALU with valid/ready on both sides,
// registered result/flags and a multi-cycle multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err,
  output logic             busy
);

  localparam int M = WIDTH - 1;

  alu_state_e       state;
  alu_op_e          op;
  logic [WIDTH-1:0] res_q;
  alu_flags_t       flags_q;
  logic             err_q;
  logic             ov_q;
  logic             busy_q;

  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] prod_lo;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;

  assign op        = alu_op_e'(opcode);
  assign in_ready  = !rst && (state == IDLE)
                     && (!ov_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL) && MUL_EN;
  assign mul_start = accept && is_mul;
  assign prod_lo   = product[WIDTH-1:0];

  assign sum  = {1'b0, op1} + {1'b0, op2};
  assign diff = {1'b0, op1} - {1'b0, op2};

  // Single-cycle datapath; MUL only reaches here when disabled.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op1[M] == op2[M])
                  && (sum[M] != op1[M]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (op1[M] != op2[M])
                  && (diff[M] != op1[M]);
      end
      OP_AND: alu_res = op1 & op2;
      OP_OR:  alu_res = op1 | op2;
      OP_XOR: alu_res = op1 ^ op2;
      OP_SHL: alu_res = op1 << op2;
      OP_SHR: alu_res = op1 >> op2;
      OP_MUL: alu_err = 1'b1;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(
        .WIDTH (WIDTH)
      ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op1),
        .b       (op2),
        .product (product),
        .done    (mul_done)
      );
    end else begin : g_nomul
      assign product  = '0;
      assign mul_done = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (ov_q && out_ready) begin
        ov_q <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state  <= BUSY;
            busy_q <= 1'b1;
          end else if (accept) begin
            res_q   <= alu_res;
            flags_q <= '{z: ~|alu_res,
                         n: alu_res[M],
                         c: alu_c,
                         v: alu_v};
            err_q   <= alu_err;
            ov_q    <= 1'b1;
          end
        end
        BUSY: begin
          if (mul_done) begin
            state  <= DONE;
            busy_q <= 1'b0;
          end
        end
        DONE: begin
          res_q   <= prod_lo;
          flags_q <= '{z: ~|prod_lo,
                       n: prod_lo[M],
                       c: |product[2*WIDTH-1:WIDTH],
                       v: 1'b0};
          err_q   <= 1'b0;
          ov_q    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = ov_q;
  assign result    = res_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=4,
// with a second instance built without the multiplier.
module tb_alu_seq;

  typedef struct packed {
    logic [3:0] r;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic       e;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_valid0;
  logic       out_ready;
  logic [2:0] opcode;
  logic [3:0] op1;
  logic [3:0] op2;

  logic       in_ready, out_valid, busy, err;
  logic       flag_z, flag_n, flag_c, flag_v;
  logic [3:0] result;
  logic       in_ready0, out_valid0, busy0, err0;
  logic       z0, n0, c0, v0;
  logic [3:0] result0;

  exp_t obs;
  exp_t obs0;
  exp_t q[$];
  int   checks;
  int   errors;

  assign obs  = {result, flag_z, flag_n, flag_c, flag_v, err};
  assign obs0 = {result0, z0, n0, c0, v0, err0};

  alu_seq #(.WIDTH(4), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .err       (err),
    .busy      (busy)
  );

  alu_seq #(.WIDTH(4), .MUL_EN(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .opcode    (opcode),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .result    (result0),
    .flag_z    (z0),
    .flag_n    (n0),
    .flag_c    (c0),
    .flag_v    (v0),
    .err       (err0),
    .busy      (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [3:0] a,
                                 input logic [3:0] b,
                                 input bit mul_en);
    int ia, ib, sa, sb, s, r;
    exp_t x;
    x  = '0;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    r  = 0;
    case (op)
      3'd0: begin
        r = ia + ib; x.c = (r > 15);
        s = sa + sb; x.v = (s > 7) || (s < -8);
      end
      3'd1: begin
        r = ia - ib; x.c = (ia < ib);
        s = sa - sb; x.v = (s > 7) || (s < -8);
      end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = (ib >= 4) ? 0 : (ia << ib);
      3'd6: r = (ib >= 4) ? 0 : (ia >> ib);
      default: begin
        if (mul_en) begin
          r = ia * ib; x.c = (r > 15);
        end else begin
          r = 0; x.e = 1'b1;
        end
      end
    endcase
    r   = r & 15;
    x.r = 4'(r);
    x.z = (r == 0);
    x.n = (r >= 8);
    return x;
  endfunction

  task automatic issue(input logic [2:0] op,
                       input logic [3:0] a,
                       input logic [3:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_wait in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1;
    opcode   = op;
    op1      = a;
    op2      = b;
    @(posedge clk);
    q.push_back(model(op, a, b, 1'b1));
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_valid0 = 1'b0;
    out_ready = 1'b1;
    opcode = '0; op1 = '0; op2 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, obs} !== '0) begin
      errors++;
      $display("FAIL reset_hold ir=%b ov=%b bz=%b obs=%h want 0",
               in_ready, out_valid, busy, obs);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, obs} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after ir=%b ov=%b bz=%b obs=%h want 1/0",
               in_ready, out_valid, busy, obs);
    end
  endtask

  task automatic test_add_sub;
    logic [2:0] ops[5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [3:0] as[5]  = '{4'hF, 4'h7, 4'h3, 4'hC, 4'h5};
    logic [3:0] bs[5]  = '{4'hF, 4'h1, 4'h5, 4'hA, 4'h8};
    exp_t want;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      @(negedge clk);
      want = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== want) begin
        errors++;
        $display("FAIL arith_%0d ov=%b obs=%h want 1 %h",
                 i, out_valid, obs, want);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops[4] = '{3'd0, 3'd1, 3'd4, 3'd6};
    logic [3:0] as[4]  = '{4'h9, 4'h8, 4'hF, 4'hE};
    logic [3:0] bs[4]  = '{4'h8, 4'h1, 4'h3, 4'h1};
    exp_t want;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    opcode = ops[0]; op1 = as[0]; op2 = bs[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      q.push_back(model(ops[i], as[i], bs[i], 1'b1));
      #1;
      if (i < 3) begin
        opcode = ops[i+1]; op1 = as[i+1]; op2 = bs[i+1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      want = q.pop_front();
      checks++;
      if (!out_valid || !in_ready || obs !== want) begin
        errors++;
        $display("FAIL b2b_%0d ov=%b ir=%b obs=%h want 1 1 %h",
                 i, out_valid, in_ready, obs, want);
      end
    end
  endtask

  task automatic test_mul;
    logic [3:0] as[2] = '{4'h3, 4'h7};
    logic [3:0] bs[2] = '{4'h5, 4'h9};
    exp_t want;
    int n;
    out_ready = 1'b1;
    issue(3'd7, 4'hF, 4'hF);
    opcode = 3'd0; op1 = 4'h0; op2 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        errors++;
        $display("FAIL mul_busy_%0d bz/ir/ov=%b want 100",
                 i, {busy, in_ready, out_valid});
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL mul_done bz/ir/ov=%b want 000",
               {busy, in_ready, out_valid});
    end
    @(negedge clk);
    want = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== want) begin
      errors++;
      $display("FAIL mul_ff ov=%b obs=%h want 1 %h",
               out_valid, obs, want);
    end
    for (int i = 0; i < 2; i++) begin
      issue(3'd7, as[i], bs[i]);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 12);
      want = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== want) begin
        errors++;
        $display("FAIL mul_%0d ov=%b obs=%h want 1 %h",
                 i, out_valid, obs, want);
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t want;
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(3'd4, 4'hA, 4'h6);
    in_valid = 1'b1;
    opcode = 3'd0; op1 = 4'h1; op2 = 4'h2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (!out_valid || in_ready || obs !== q[0]) begin
        errors++;
        $display("FAIL stall_%0d ov=%b ir=%b obs=%h want 1 0 %h",
                 i, out_valid, in_ready, obs, q[0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    void'(q.pop_front());
    q.push_back(model(3'd0, 4'h1, 4'h2, 1'b1));
    #1 in_valid = 1'b0;
    @(negedge clk);
    want = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== want) begin
      errors++;
      $display("FAIL drain_accept ov=%b obs=%h want 1 %h",
               out_valid, obs, want);
    end
  endtask

  task automatic test_shift;
    logic [2:0] ops[3] = '{3'd5, 3'd6, 3'd5};
    logic [3:0] as[3]  = '{4'h3, 4'h8, 4'h1};
    logic [3:0] bs[3]  = '{4'h2, 4'h5, 4'h4};
    exp_t want;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      @(negedge clk);
      want = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== want) begin
        errors++;
        $display("FAIL shift_%0d ov=%b obs=%h want 1 %h",
                 i, out_valid, obs, want);
      end
    end
  endtask

  task automatic test_illegal;
    logic [2:0] ops[2] = '{3'd7, 3'd0};
    exp_t want;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid0 = 1'b1;
      opcode = ops[i]; op1 = 4'hF; op2 = 4'hF;
      checks++;
      if (in_ready0 !== 1'b1) begin
        errors++;
        $display("FAIL illegal_ready_%0d ir=%b want 1",
                 i, in_ready0);
      end
      @(posedge clk);
      #1 in_valid0 = 1'b0;
      @(negedge clk);
      want = model(ops[i], 4'hF, 4'hF, 1'b0);
      checks++;
      if (!out_valid0 || busy0 || obs0 !== want) begin
        errors++;
        $display("FAIL illegal_%0d ov=%b bz=%b obs=%h want 1 0 %h",
                 i, out_valid0, busy0, obs0, want);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    exp_t want;
    out_ready = 1'b1;
    issue(3'd7, 4'h5, 4'h3);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    q.delete();
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst ov/bz/ir=%b want 000",
               {out_valid, busy, in_ready});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    issue(3'd0, 4'h1, 4'h1);
    @(negedge clk);
    want = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== want) begin
      errors++;
      $display("FAIL post_rst_add ov=%b obs=%h want 1 %h",
               out_valid, obs, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_shift();
    test_illegal();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
